// File: rtl/mac_seq_ctrl.sv
// Sequencer for a chain of NMAC MAC units: loads one weight per unit, streams activations, tracks result validity.
// Optional macro MAC_SEQ_ABORT_EN adds an abort input that cancels the running job.
module mac_seq_ctrl #(
    parameter int DW      = 8,
    parameter int NMAC    = 8,
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MAC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             w_in_valid,
    output logic             w_in_ready,
    input  logic [DW-1:0]    w_in_data,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [DW-1:0]    x_data,
    output logic [NMAC-1:0]  mac_w_en,
    output logic [DW-1:0]    mac_w_data,
    output logic [DW-1:0]    mac_x_data,
    output logic             res_valid,
    output logic             res_last,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (NMAC > 1) ? $clog2(NMAC) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   w_idx;
    logic [LEN_W-1:0]   vec_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [MAC_LAT-1:0] vld_p;
    logic [MAC_LAT-1:0] last_p;
    logic               abort_req;
    logic               w_hs;
    logic               x_hs;
    logic               w_last;
    logic               x_last;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_req = abort & (state_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // An aborted cycle must not consume a beat, so handshakes are masked by abort.
    assign w_in_ready = (state_q == LOAD_W);
    assign x_ready    = (state_q == RUN) && (vec_cnt < len_q);
    assign w_hs       = w_in_ready & w_in_valid & ~abort_req;
    assign x_hs       = x_ready & x_valid & ~abort_req;
    assign w_last     = (w_idx == IDX_W'(NMAC - 1));
    assign x_last     = (vec_cnt == len_q - 1'b1);

    assign mac_w_en   = w_hs ? (NMAC'(1) << w_idx) : '0;
    assign mac_w_data = w_in_data;
    assign mac_x_data = x_hs ? x_data : '0;

    assign res_valid  = vld_p[MAC_LAT-1];
    assign res_last   = vld_p[MAC_LAT-1] & last_p[MAC_LAT-1];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD_W;
            LOAD_W:  if (w_hs && w_last) state_d = (len_q != '0) ? RUN : DRAIN;
            RUN:     if (x_hs && x_last) state_d = DRAIN;
            DRAIN:   if (vld_p == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_req) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_idx   <= '0;
            vec_cnt <= '0;
            len_q   <= '0;
            vld_p   <= '0;
            last_p  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                len_q   <= cfg_len;
                w_idx   <= '0;
                vec_cnt <= '0;
            end
            if (w_hs) w_idx <= w_idx + 1'b1;
            if (x_hs) vec_cnt <= vec_cnt + 1'b1;
            // Result-valid pipeline stage boundary: one token per accepted vector.
            if (abort_req) begin
                vld_p  <= '0;
                last_p <= '0;
            end else begin
                vld_p  <= (vld_p << 1) | MAC_LAT'(x_hs);
                last_p <= (last_p << 1) | MAC_LAT'(x_hs & x_last);
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized bench for mac_seq_ctrl (NMAC=4, MAC_LAT=4) against a job-level reference model.
module tb_mac_seq_ctrl;

    localparam int DW      = 8;
    localparam int NMAC    = 4;
    localparam int LEN_W   = 16;
    localparam int MAC_LAT = 4;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_DONE  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             abort;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             w_in_valid;
    logic             w_in_ready;
    logic [DW-1:0]    w_in_data;
    logic             x_valid;
    logic             x_ready;
    logic [DW-1:0]    x_data;
    logic [NMAC-1:0]  mac_w_en;
    logic [DW-1:0]    mac_w_data;
    logic [DW-1:0]    mac_x_data;
    logic             res_valid;
    logic             res_last;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.DW(DW), .NMAC(NMAC), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MAC_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .cfg_len    (cfg_len),
        .w_in_valid (w_in_valid),
        .w_in_ready (w_in_ready),
        .w_in_data  (w_in_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .mac_w_en   (mac_w_en),
        .mac_w_data (mac_w_data),
        .mac_x_data (mac_x_data),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: job phase, beat/vector counts, and a queue of result due-times.
    typedef struct {
        int due;
        bit last;
    } tok_t;

    tok_t m_q[$];
    int   m_phase = PH_IDLE;
    int   m_beat  = 0;
    int   m_acc   = 0;
    int   m_len   = 0;
    int   m_cyc   = 0;
    int   rv_seen, rl_seen, done_seen;

    task automatic step();
        logic [NMAC-1:0] e_wen;
        bit whs, xhs, e_xr, e_rv, e_rl, pipe_empty;
        whs   = (m_phase == PH_LOAD) && w_in_valid && !abort;
        e_xr  = (m_phase == PH_RUN) && (m_acc < m_len);
        xhs   = e_xr && x_valid && !abort;
        e_wen = '0;
        if (whs) e_wen[m_beat] = 1'b1;
        pipe_empty = (m_q.size() == 0);
        e_rv = !pipe_empty && (m_q[0].due == m_cyc);
        e_rl = e_rv && m_q[0].last;

        check_eq("busy",       32'(busy),       32'(m_phase != PH_IDLE));
        check_eq("done",       32'(done),       32'(m_phase == PH_DONE));
        check_eq("w_in_ready", 32'(w_in_ready), 32'(m_phase == PH_LOAD));
        check_eq("mac_w_en",   32'(mac_w_en),   32'(e_wen));
        check_eq("x_ready",    32'(x_ready),    32'(e_xr));
        check_eq("mac_x_data", 32'(mac_x_data), xhs ? 32'(x_data) : 32'd0);
        check_eq("mac_w_data", 32'(mac_w_data), 32'(w_in_data));
        check_eq("res_valid",  32'(res_valid),  32'(e_rv));
        check_eq("res_last",   32'(res_last),   32'(e_rl));
        if (res_valid) rv_seen++;
        if (res_last) rl_seen++;
        if (done) done_seen++;

        if (e_rv) void'(m_q.pop_front());
        if (rst || (abort && m_phase != PH_IDLE)) begin
            m_phase = PH_IDLE;
            m_q.delete();
        end else begin
            case (m_phase)
                PH_IDLE: if (start) begin
                    m_phase = PH_LOAD;
                    m_len   = int'(cfg_len);
                    m_beat  = 0;
                    m_acc   = 0;
                end
                PH_LOAD: if (whs) begin
                    m_beat++;
                    if (m_beat == NMAC) m_phase = (m_len != 0) ? PH_RUN : PH_DRAIN;
                end
                PH_RUN: if (xhs) begin
                    m_q.push_back('{due: m_cyc + MAC_LAT, last: (m_acc == m_len - 1)});
                    m_acc++;
                    if (m_acc == m_len) m_phase = PH_DRAIN;
                end
                PH_DRAIN: if (pipe_empty) m_phase = PH_DONE;
                default:  m_phase = PH_IDLE;
            endcase
        end
        m_cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    // wmode: 0 = always valid, 1 = random; xmode: 0 = always, 1 = alternating, 2 = random.
    task automatic run_job(input int len, input int wmode, input int xmode, input bit noise,
                           input int rst_at, input bit abort_drain);
        bit first = 1'b1;
        bit left_idle = 1'b0;
        bit interrupted = 1'b0;
        int budget = 0;
        int xpar = 0;
        rv_seen = 0;
        rl_seen = 0;
        done_seen = 0;
        while (!(left_idle && m_phase == PH_IDLE) && budget < 400) begin
            start      = first ? 1'b1 : (noise && m_phase != PH_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_len    = first ? LEN_W'(len) : LEN_W'($urandom_range(0, 7));
            w_in_valid = (wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            w_in_data  = DW'($urandom);
            x_valid    = (xmode == 0) ? 1'b1 : (xmode == 1) ? (xpar % 2 == 0) : 1'($urandom_range(0, 1));
            x_data     = DW'($urandom_range(1, 255));
            rst        = !interrupted && rst_at >= 0 && m_phase == PH_RUN && m_acc == rst_at;
            abort      = !interrupted && abort_drain && m_phase == PH_DRAIN;
            if (rst || abort) interrupted = 1'b1;
            if (m_phase == PH_RUN) xpar++;
            tick();
            if (m_phase != PH_IDLE) left_idle = 1'b1;
            first = 1'b0;
            budget++;
        end
        check_eq("job_in_budget", 32'(budget < 400), 32'd1);
        rst = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        w_in_valid = 1'b0;
        x_valid = 1'b0;
        repeat (6) tick();
        if (interrupted) begin
            check_eq("no_done_after_cut", 32'(done_seen), 32'd0);
        end else begin
            check_eq("res_count", 32'(rv_seen), 32'(len));
            check_eq("last_count", 32'(rl_seen), 32'(len > 0));
            check_eq("done_count", 32'(done_seen), 32'd1);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        cfg_len = '0;
        w_in_valid = 1'b1;
        w_in_data = 8'h5a;
        x_valid = 1'b1;
        x_data = 8'h33;
        @(posedge clk);
        #1;
        tick();
        tick();
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        w_in_valid = 1'b0;
        x_valid = 1'b0;
        tick();

        run_job(3, 0, 0, 1'b0, -1, 1'b0);
        run_job(0, 0, 0, 1'b0, -1, 1'b0);
        run_job(5, 0, 1, 1'b0, -1, 1'b0);
        run_job(5, 0, 0, 1'b0, 2, 1'b0);
        check_eq("idle_after_rst", 32'(busy), 32'd0);
        run_job(4, 1, 2, 1'b1, -1, 1'b0);
`ifdef MAC_SEQ_ABORT_EN
        run_job(3, 0, 0, 1'b0, -1, 1'b1);
        run_job(6, 1, 2, 1'b0, -1, 1'b1);
`endif
        for (int j = 0; j < 10; j++) begin
            run_job($urandom_range(0, 6), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    1'b1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter DW, default 8: activation/weight width, matching the MAC operand width.
REQ-002 Parameter NMAC, default 8: number of MAC units in the chain; weight beats per load.
REQ-003 Parameter LEN_W, default 16: width of the vector-count field.
REQ-004 Parameter MAC_LAT, default 4: cycles from operand capture to MAC result register.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin job; sampled only in IDLE.
REQ-008 cfg_len  in  LEN_W  activation vectors per job; sampled with start.
REQ-009 w_in_valid / w_in_ready  in / out  1 / 1  weight stream handshake.
REQ-010 w_in_data  in  DW  weight beat.
REQ-011 x_valid / x_ready  in / out  1 / 1  activation stream handshake.
REQ-012 x_data  in  DW  activation.
REQ-013 mac_w_en  out  NMAC  one-hot weight-capture enable to the MAC units.
REQ-014 mac_w_data  out  DW  equals w_in_data, combinationally.
REQ-015 mac_x_data  out  DW  x_data when an activation handshake occurs, else 0.
REQ-016 res_valid  out  1  MAC chain output is a real result this cycle.
REQ-017 res_last  out  1  res_valid for the final vector of the job.
REQ-018 busy  out  1  state != IDLE.
REQ-019 done  out  1  one-cycle job-complete pulse.

Function
REQ-020 FSM states: IDLE, LOAD_W, RUN, DRAIN, DONE.
REQ-021 IDLE: start=1 -> LOAD_W next cycle and cfg_len is latched; start in any other state is ignored.
REQ-022 LOAD_W: w_in_ready=1; on the k-th handshake (k=0..NMAC-1), mac_w_en bit k=1 in the same cycle and all other bits are 0.
REQ-023 LOAD_W: after beat NMAC-1 -> RUN if the latched length != 0, else DRAIN.
REQ-024 RUN: x_ready=1 while accepted count < latched length, otherwise 0.
REQ-025 RUN: after the final accepted vector -> DRAIN next cycle.
REQ-026 Each accepted activation shifts a token into a MAC_LAT-deep valid pipeline; res_valid is asserted exactly MAC_LAT cycles after the acceptance cycle; non-handshake cycles insert bubbles.
REQ-027 res_last shall accompany the token of the vector with index length-1.
REQ-028 DRAIN: -> DONE once the valid pipeline is empty; DONE asserts done=1 for one cycle, then -> IDLE.
REQ-029 The job shall produce exactly latched-length res_valid pulses in order, with no duplicates.
REQ-030 Counters: weight index ceil(log2 NMAC) bits; vector count LEN_W bits, no wrap (max length 2^LEN_W-1).
REQ-031 w_in_ready, x_ready and mac_w_en shall be 0 outside LOAD_W and RUN respectively.

Reset
REQ-032 rst=1 at a clock edge -> IDLE with all counters and the valid pipeline cleared.
REQ-033 Reset values: all outputs 0; mac_w_data follows its input.
REQ-034 Reset during any state shall abandon the job; no res_valid or done shall follow.

Configuration
REQ-035 Macro MAC_SEQ_ABORT_EN, when defined, adds input abort (1 bit).
REQ-036 With MAC_SEQ_ABORT_EN: abort=1 in any non-IDLE state -> IDLE next cycle, the valid pipeline is cleared, and no done is issued; abort has priority over a simultaneous handshake, and that handshake is not counted.
REQ-037 Without MAC_SEQ_ABORT_EN: the port is absent and a job runs to DONE.

Verification (NMAC=4, MAC_LAT=4)
REQ-038 start, cfg_len=3, continuous streams -> mac_w_en 0001,0010,0100,1000 on consecutive cycles; 3 res_valid pulses 4 cycles after each x handshake; res_last on the 3rd; done once.
REQ-039 cfg_len=0 -> 4 weight beats, no x_ready, no res_valid, done pulse.
REQ-040 cfg_len=5, x_valid toggling 1,0,1,0,... -> res_valid pattern mirrors the acceptance pattern delayed 4 cycles; mac_x_data=0 in bubble cycles.
REQ-041 rst during RUN after 2 of 5 vectors -> busy=0 next cycle; no further res_valid or done.
REQ-042 start asserted while busy -> ignored; the job completes with the original cfg_len.
REQ-043 MAC_SEQ_ABORT_EN defined, abort in DRAIN -> IDLE next cycle; pending res_valid suppressed; no done.
